// File: rtl/opcode_executor.sv
// Responder end of the 12-bit opcode interface: executes one opcode at a time
// against working registers A/B/C and result registers Ao/Bo/Co.
module opcode_executor #(
  parameter int WIDTH    = 16,
  parameter int MUL_ITER = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [11:0]      opcode,
  input  logic [WIDTH-1:0] Mem_Dat_X,
  input  logic [WIDTH-1:0] Mem_Dat_Y,
  output logic [WIDTH-1:0] Aout,
  output logic [WIDTH-1:0] Bout,
  output logic [WIDTH-1:0] Cout,
  output logic             done,
  output logic             err,
  output logic             carry,
  output logic             zero
);

  localparam int CW = $clog2(MUL_ITER) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MUL = 2'd2} state_t;

  state_t state, next_state;

  logic [WIDTH-1:0]   a, b, c, ao, bo, co;
  logic [2*WIDTH-1:0] acc, acc_next, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic [1:0]         mul_dst;
  logic               mul_last;

  logic [2:0]       kind, func;
  logic [1:0]       f1, f2, f3;
  logic [WIDTH-1:0] p_val, q_val, alu_val, move_val, wr_val;
  logic             alu_carry, alu_ok, is_mul;
  logic             illegal, wr_work, wr_res, start_mul;
  logic [1:0]       work_dst;

  assign kind = opcode[11:9];
  assign f1   = opcode[8:7];
  assign f2   = opcode[6:5];
  assign f3   = opcode[4:3];
  assign func = opcode[2:0];

  assign Aout = ao;
  assign Bout = bo;
  assign Cout = co;

  assign mul_last = (cnt == CW'(MUL_ITER - 1));

  // ALU operand code: 00 A, 01 B, 10 C, 11 Ao
  function automatic logic [WIDTH-1:0] pick_op(input logic [1:0] sel,
                                               input logic [WIDTH-1:0] ra, rb, rc, rao);
    case (sel)
      2'b00:   pick_op = ra;
      2'b01:   pick_op = rb;
      2'b10:   pick_op = rc;
      default: pick_op = rao;
    endcase
  endfunction

  assign p_val = pick_op(f2, a, b, c, ao);
  assign q_val = pick_op(f3, a, b, c, ao);

  // single-cycle ALU functions; MUL is only flagged here
  always_comb begin
    alu_val   = '0;
    alu_carry = 1'b0;
    alu_ok    = 1'b1;
    is_mul    = 1'b0;
    case (func)
      3'b000: {alu_carry, alu_val} = {1'b0, p_val} + {1'b0, q_val};
      3'b001: alu_val = ~p_val + WIDTH'(1);
      3'b010: begin
        alu_val   = {1'b0, p_val[WIDTH-1:1]};
        alu_carry = p_val[0];
      end
      3'b011: begin
        alu_val   = {p_val[WIDTH-2:0], 1'b0};
        alu_carry = p_val[WIDTH-1];
      end
      3'b100: alu_val = p_val & {WIDTH{q_val[0]}};
      3'b101: begin
        alu_val   = p_val - q_val;
        alu_carry = (p_val >= q_val);
      end
      3'b110: is_mul = 1'b1;
      default: alu_ok = 1'b0;
    endcase
  end

  // MOVE source: 00 Ao, 01 Bo, 10 Co
  always_comb begin
    case (f1)
      2'b00:   move_val = ao;
      2'b01:   move_val = bo;
      2'b10:   move_val = co;
      default: move_val = '0;
    endcase
  end

  // opcode decode into write enables and the value to be written
  always_comb begin
    illegal  = 1'b0;
    wr_work  = 1'b0;
    wr_res   = 1'b0;
    wr_val   = '0;
    work_dst = f1;
    case (kind)
      3'b000: illegal = 1'b0;
      3'b001: begin
        if (f1 == 2'b11 || !alu_ok) begin
          illegal = 1'b1;
        end else if (!is_mul) begin
          wr_res = 1'b1;
          wr_val = alu_val;
        end else begin
          wr_res = 1'b0;
        end
      end
      3'b010: begin
        if (f1 == 2'b11) begin
          illegal = 1'b1;
        end else begin
          wr_work = 1'b1;
          wr_val  = opcode[0] ? Mem_Dat_Y : Mem_Dat_X;
        end
      end
      3'b011: begin
        work_dst = f2;
        if (f1 == 2'b11 || f2 == 2'b11) begin
          illegal = 1'b1;
        end else begin
          wr_work = 1'b1;
          wr_val  = move_val;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

  assign start_mul = (kind == 3'b001) && is_mul && !illegal;

  // one shift-add step of the multiplier
  always_comb begin
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end else begin
      acc_next = acc;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (op_valid) begin
          next_state = start_mul ? MUL : EXEC;
        end else begin
          next_state = IDLE;
        end
      end
      EXEC: next_state = IDLE;
      MUL: begin
        if (mul_last) begin
          next_state = IDLE;
        end else begin
          next_state = MUL;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // handshake output
  always_comb begin
    op_ready = (state == IDLE);
  end

  // datapath: single-cycle ops retire on the accept edge, MUL on its last step
  always_ff @(posedge clk) begin
    if (rst) begin
      a       <= '0;
      b       <= '0;
      c       <= '0;
      ao      <= '0;
      bo      <= '0;
      co      <= '0;
      carry   <= 1'b0;
      zero    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      mul_dst <= 2'b00;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state == IDLE && op_valid) begin
        if (illegal) begin
          done <= 1'b1;
          err  <= 1'b1;
        end else if (start_mul) begin
          acc     <= '0;
          mcand   <= {{WIDTH{1'b0}}, p_val};
          mplier  <= q_val;
          cnt     <= '0;
          mul_dst <= f1;
        end else begin
          done <= 1'b1;
          if (wr_work) begin
            case (work_dst)
              2'b00:   a <= wr_val;
              2'b01:   b <= wr_val;
              2'b10:   c <= wr_val;
              default: a <= a;
            endcase
          end
          if (wr_res) begin
            case (f1)
              2'b00:   ao <= wr_val;
              2'b01:   bo <= wr_val;
              2'b10:   co <= wr_val;
              default: ao <= ao;
            endcase
            carry <= alu_carry;
            zero  <= (alu_val == '0);
          end
        end
      end else if (state == MUL) begin
        acc    <= acc_next;
        mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
        mplier <= {1'b0, mplier[WIDTH-1:1]};
        cnt    <= cnt + CW'(1);
        if (mul_last) begin
          case (mul_dst)
            2'b00:   ao <= acc_next[WIDTH-1:0];
            2'b01:   bo <= acc_next[WIDTH-1:0];
            2'b10:   co <= acc_next[WIDTH-1:0];
            default: ao <= ao;
          endcase
          carry <= |acc_next[2*WIDTH-1:WIDTH];
          zero  <= (acc_next[WIDTH-1:0] == '0);
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_opcode_executor.sv
// Directed self-checking bench for opcode_executor; expected values hand-computed.
module tb_opcode_executor;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             op_valid;
  logic             op_ready;
  logic [11:0]      opcode;
  logic [WIDTH-1:0] Mem_Dat_X, Mem_Dat_Y;
  logic [WIDTH-1:0] Aout, Bout, Cout;
  logic             done, err, carry, zero;

  int vectors = 0;
  int miscompares = 0;

  opcode_executor #(.WIDTH(WIDTH), .MUL_ITER(16)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .opcode(opcode), .Mem_Dat_X(Mem_Dat_X), .Mem_Dat_Y(Mem_Dat_Y),
    .Aout(Aout), .Bout(Bout), .Cout(Cout),
    .done(done), .err(err), .carry(carry), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive one opcode for a single accept edge; caller sits just after an edge
  task automatic send(input logic [11:0] op, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    chk("ready_before_send", op_ready, 16'h0001);
    opcode    = op;
    Mem_Dat_X = x;
    Mem_Dat_Y = y;
    op_valid  = 1'b1;
    tick();
    op_valid  = 1'b0;
  endtask

  task automatic exec(input logic [11:0] op, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    send(op, x, y);
    chk("exec_done", done, 16'h0001);
    chk("exec_err", err, 16'h0000);
    chk("exec_ready_low", op_ready, 16'h0000);
    tick();
    chk("exec_done_clear", done, 16'h0000);
    chk("exec_ready_back", op_ready, 16'h0001);
  endtask

  task automatic illegal_op(input logic [11:0] op, input logic [WIDTH-1:0] x);
    send(op, x, x);
    chk("ill_done", done, 16'h0001);
    chk("ill_err", err, 16'h0001);
    tick();
    chk("ill_done_clear", done, 16'h0000);
    chk("ill_err_clear", err, 16'h0000);
  endtask

  // MUL B,C->Ao with an illegal opcode held on the bus while busy
  task automatic do_mul();
    send(12'h236, 16'h0000, 16'h0000);
    chk("mul_no_early_done", done, 16'h0000);
    opcode   = 12'hE00;
    op_valid = 1'b1;
    for (int i = 1; i < 16; i++) begin
      chk("mul_ready_low", op_ready, 16'h0000);
      tick();
      chk("mul_busy_done", done, 16'h0000);
    end
    op_valid = 1'b0;
    tick();
    chk("mul_done", done, 16'h0001);
    chk("mul_err", err, 16'h0000);
    chk("mul_ready", op_ready, 16'h0001);
  endtask

  initial begin
    rst       = 1'b1;
    op_valid  = 1'b0;
    opcode    = 12'h000;
    Mem_Dat_X = 16'h0000;
    Mem_Dat_Y = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", done, 16'h0000);
    chk("rst_err", err, 16'h0000);
    chk("rst_aout", Aout, 16'h0000);
    chk("rst_bout", Bout, 16'h0000);
    chk("rst_cout", Cout, 16'h0000);
    chk("rst_carry", carry, 16'h0000);
    chk("rst_zero", zero, 16'h0000);
    rst = 1'b0;
    tick();
    chk("rst_ready", op_ready, 16'h0001);

    exec(12'h480, 16'h0005, 16'h0003);   // LOAD X->B
    exec(12'h501, 16'h0005, 16'h0003);   // LOAD Y->C
    exec(12'h230, 16'h0000, 16'h0000);   // ADD B,C->Ao
    chk("add_aout", Aout, 16'h0008);
    chk("add_carry", carry, 16'h0000);
    chk("add_zero", zero, 16'h0000);

    exec(12'h221, 16'h0000, 16'h0000);   // NEG B->Ao
    chk("neg_aout", Aout, 16'hFFFB);
    chk("neg_carry", carry, 16'h0000);
    exec(12'h222, 16'h0000, 16'h0000);   // SHR B->Ao
    chk("shr_aout", Aout, 16'h0002);
    chk("shr_carry", carry, 16'h0001);
    exec(12'h620, 16'h0000, 16'h0000);   // MOVE Ao->B
    exec(12'h222, 16'h0000, 16'h0000);
    chk("move_shr_aout", Aout, 16'h0001);
    chk("move_shr_carry", carry, 16'h0000);

    exec(12'h480, 16'h0005, 16'h0000);   // B=5, C still 3
    do_mul();
    chk("mul15_aout", Aout, 16'h000F);
    chk("mul15_carry", carry, 16'h0000);
    chk("mul15_zero", zero, 16'h0000);

    exec(12'h480, 16'h0100, 16'h0000);
    exec(12'h500, 16'h0100, 16'h0000);
    do_mul();
    chk("mulovf_aout", Aout, 16'h0000);
    chk("mulovf_carry", carry, 16'h0001);
    chk("mulovf_zero", zero, 16'h0001);

    exec(12'h480, 16'hFFFF, 16'h0000);
    exec(12'h501, 16'h0000, 16'h0001);
    exec(12'h230, 16'h0000, 16'h0000);
    chk("addwrap_aout", Aout, 16'h0000);
    chk("addwrap_carry", carry, 16'h0001);
    chk("addwrap_zero", zero, 16'h0001);

    exec(12'h321, 16'h0000, 16'h0000);   // NEG B->Co
    chk("negco_cout", Cout, 16'h0001);
    chk("negco_zero", zero, 16'h0000);

    illegal_op(12'hE00, 16'h1234);
    illegal_op(12'h580, 16'h1234);       // LOAD dst=11
    chk("ill_aout", Aout, 16'h0000);
    chk("ill_bout", Bout, 16'h0000);
    chk("ill_cout", Cout, 16'h0001);
    chk("ill_carry", carry, 16'h0000);
    chk("ill_zero", zero, 16'h0000);
    exec(12'h2A2, 16'h0000, 16'h0000);   // SHR B->Bo proves B untouched
    chk("ill_b_kept", Bout, 16'h7FFF);
    chk("ill_b_carry", carry, 16'h0001);

    send(12'h236, 16'h0000, 16'h0000);   // MUL FFFF*1, aborted by reset
    repeat (7) tick();
    rst = 1'b1;
    tick();
    chk("abort_done", done, 16'h0000);
    chk("abort_aout", Aout, 16'h0000);
    chk("abort_bout", Bout, 16'h0000);
    chk("abort_cout", Cout, 16'h0000);
    chk("abort_carry", carry, 16'h0000);
    chk("abort_zero", zero, 16'h0000);
    chk("abort_ready", op_ready, 16'h0001);
    rst = 1'b0;
    for (int i = 0; i < 18; i++) begin
      tick();
      chk("abort_no_done", done, 16'h0000);
    end
    chk("abort_ready_after", op_ready, 16'h0001);
    exec(12'h200, 16'h0000, 16'h0000);   // ADD A,A->Ao with A cleared
    chk("post_rst_aout", Aout, 16'h0000);
    chk("post_rst_zero", zero, 16'h0001);
    chk("post_rst_carry", carry, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
